// File: rtl/mux_2x1_st.sv
// mux_2x1_st: gate-level WIDTH-lane 2:1 mux (out = select ? b : a) plus an en-gated registered copy (out_q/out_valid) with sync active-low reset rst_n
module mux_2x1_st #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);
  logic             sel_n;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  not g_not (sel_n, select);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      and g_and_a (pick_a[i], sel_n, a[i]);
      and g_and_b (pick_b[i], select, b[i]);
      or  g_or    (out[i], pick_a[i], pick_b[i]);
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_2x1_st.sv
// tb_mux_2x1_st: randomized self-checking bench for mux_2x1_st at WIDTH=8 and WIDTH=1
module tb_mux_2x1_st;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] a, b;
  logic       select;
  logic [7:0] out, out_q;
  logic       out_valid;
  logic       a1, b1, s1;
  logic       o1, q1, v1;
  logic [7:0] mq;
  logic       mv, m1q;
  int passed = 0;
  int total  = 0;

  always #10 clk = ~clk;

  mux_2x1_st #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select), .en(en),
    .out(out), .out_q(out_q), .out_valid(out_valid)
  );

  mux_2x1_st #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .select(s1), .en(en),
    .out(o1), .out_q(q1), .out_valid(v1)
  );

  task automatic tick();
    if (!rst_n) begin
      mq = 8'h00; m1q = 1'b0; mv = 1'b0;
    end else if (en) begin
      mq = select ? b : a; m1q = s1 ? b1 : a1; mv = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; select = 1'b1; a = 8'h5A; b = 8'hC3; s1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    tick();
    tick();
    total++; if (out_q !== 8'h00) $display("FAIL reset_out_q got=%h exp=00", out_q); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (q1 !== 1'b0) $display("FAIL reset_out_q_w1 got=%b exp=0", q1); else passed++;
    total++; if (v1 !== 1'b0) $display("FAIL reset_out_valid_w1 got=%b exp=0", v1); else passed++;
  endtask

  task automatic test_truth_table();
    logic [7:0] tt;
    logic [2:0] idx;
    tt = 8'hAC;
    for (int k = 0; k < 8; k++) begin
      idx = 3'(k);
      {s1, a1, b1} = idx;
      #10;
      total++; if (o1 !== tt[idx]) $display("FAIL truth_sel%b_a%b_b%b got=%b exp=%b", s1, a1, b1, o1, tt[idx]); else passed++;
      total++; if (q1 !== 1'b0) $display("FAIL transparent_out_q got=%b exp=0", q1); else passed++;
    end
  endtask

  task automatic test_lanes();
    a = 8'hA5; b = 8'h3C; select = 1'b0;
    #10;
    total++; if (out !== 8'hA5) $display("FAIL lanes_sel0 got=%h exp=a5", out); else passed++;
    select = 1'b1;
    #10;
    total++; if (out !== 8'h3C) $display("FAIL lanes_sel1 got=%h exp=3c", out); else passed++;
    total++; if (out_q !== 8'h00) $display("FAIL lanes_out_q_in_reset got=%h exp=00", out_q); else passed++;
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; select = 1'b1; a = 8'h00; b = 8'h01; s1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    total++; if (out_q !== 8'h01) $display("FAIL capture_out_q got=%h exp=01", out_q); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL capture_out_valid got=%b exp=1", out_valid); else passed++;
    total++; if (q1 !== 1'b1) $display("FAIL capture_out_q_w1 got=%b exp=1", q1); else passed++;
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      select = ~select; a = 8'($urandom); b = 8'($urandom); s1 = ~s1; a1 = 1'($urandom); b1 = 1'($urandom);
      #5;
      total++; if (out !== (select ? b : a)) $display("FAIL hold_out got=%h exp=%h", out, select ? b : a); else passed++;
      tick();
      total++; if (out_q !== mq) $display("FAIL hold_out_q got=%h exp=%h", out_q, mq); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid got=%b exp=1", out_valid); else passed++;
      total++; if (q1 !== m1q) $display("FAIL hold_out_q_w1 got=%b exp=%b", q1, m1q); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    en = 1'b1; select = 1'b0; a = 8'hFF; s1 = 1'b0; a1 = 1'b1;
    tick();
    rst_n = 1'b0;
    #5;
    total++; if (out_q !== 8'hFF) $display("FAIL midreset_before_edge got=%h exp=ff", out_q); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL midreset_valid_before_edge got=%b exp=1", out_valid); else passed++;
    tick();
    total++; if (out_q !== 8'h00) $display("FAIL midreset_out_q got=%h exp=00", out_q); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (q1 !== 1'b0) $display("FAIL midreset_out_q_w1 got=%b exp=0", q1); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      rst_n = ($urandom_range(0, 7) != 0);
      en = 1'($urandom);
      select = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      s1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      #5;
      total++; if (out !== (select ? b : a)) $display("FAIL rand_out got=%h exp=%h", out, select ? b : a); else passed++;
      total++; if (o1 !== (s1 ? b1 : a1)) $display("FAIL rand_out_w1 got=%b exp=%b", o1, s1 ? b1 : a1); else passed++;
      tick();
      total++; if (out_q !== mq) $display("FAIL rand_out_q got=%h exp=%h", out_q, mq); else passed++;
      total++; if (out_valid !== mv) $display("FAIL rand_out_valid got=%b exp=%b", out_valid, mv); else passed++;
      total++; if (q1 !== m1q) $display("FAIL rand_out_q_w1 got=%b exp=%b", q1, m1q); else passed++;
      total++; if (v1 !== mv) $display("FAIL rand_out_valid_w1 got=%b exp=%b", v1, mv); else passed++;
    end
  endtask

  initial begin
    mq = 8'h00; m1q = 1'b0; mv = 1'b0;
    test_reset();
    test_truth_table();
    test_lanes();
    test_capture();
    test_hold();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
